sist_seguridad_zonas: RTL
=========================

Name: sist_seguridad_zonas

Overview:
- Parametrised N-zone alarm controller that generalises the single-door/window/motion security FSM.
- Adds per-zone bypass, entry and exit delays, instant versus delayed zones, a tripped-zone memory and wrong-code lockout.
- Sits between the debounced sensor and keypad logic and the siren, LED and beeper drivers.

Parameters:
- N_ZONES, 6, number of sensor zones.
- CODE_W, 4, keypad code width in bits.
- PASSCODE, 4'hA, valid disarm/arm code (CODE_W bits).
- DELAY_ZONES, 6'b000001, zone bitmask; 1 = delayed (entry-delay) zone, 0 = instant zone.
- EXIT_CYCLES, 8, exit-delay length in clk cycles (>=1).
- ENTRY_CYCLES, 16, entry-delay length in clk cycles (>=1).
- MAX_TRIES, 3, consecutive wrong codes that trigger lockout (>=1).
- LOCK_CYCLES, 32, lockout length in clk cycles (>=1).
- SIREN_CYCLES, 64, siren auto-silence time (used only with SIREN_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- code_vld  in  1  one-cycle strobe; code is valid this cycle.
- code  in  CODE_W  keypad code.
- zone  in  N_ZONES  1 = zone open/tripped; already synchronised and debounced.
- zone_mask  in  N_ZONES  1 = zone bypassed (ignored); sampled live every cycle.
- armed  out  1  system armed (any state other than DISARMED).
- siren  out  1  alarm output.
- beeper  out  1  high during EXIT or ENTRY.
- lockout  out  1  keypad locked.
- ready  out  1  all unmasked zones closed (combinational).
- zone_mem  out  N_ZONES  latched tripped zones.
- fail_cnt  out  clog2(MAX_TRIES+1)  consecutive wrong codes.
- state  out  3  FSM state encoding.

Behaviour:
- Reset, asynchronous: state=DISARMED and all registered outputs 0. fail_cnt, zone_mem, lockout and timers all clear.
- Definitions:
  - active = zone & ~zone_mask (plus the auto-bypass under the optional feature).
  - good = code_vld & ~lockout & (code==PASSCODE).
  - bad = code_vld & ~lockout & (code!=PASSCODE).
  - code_vld during lockout is ignored entirely.
- State encoding: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4. All outputs are registered, so they reflect the state one cycle after the causing input.
- DISARMED:
  - good & ready -> EXIT; load the exit timer and clear zone_mem.
  - good & ~ready -> stay; fail_cnt still clears.
- EXIT:
  - good -> DISARMED.
  - Zones are ignored.
  - Stay exactly EXIT_CYCLES cycles, then -> ARMED.
- ARMED:
  - good -> DISARMED.
  - Else any active bit -> zone_mem |= active.
    - If any active bit is an instant zone -> ALARM.
    - Else -> ENTRY; load the entry timer.
- ENTRY:
  - good -> DISARMED.
  - Else an active instant zone -> ALARM immediately.
  - Else after ENTRY_CYCLES cycles -> ALARM.
  - zone_mem keeps accumulating.
- ALARM:
  - siren=1.
  - good -> DISARMED.
  - zone_mem keeps accumulating.
- Priority: good beats any simultaneous zone trip or timer expiry in the same cycle, including the final cycle of ENTRY.
- zone_mem is held through disarm for inspection and is cleared only on the DISARMED->EXIT transition.
- fail_cnt:
  - bad increments it; good clears it.
  - When fail_cnt reaches MAX_TRIES: lockout=1 for LOCK_CYCLES cycles, then lockout=0 and fail_cnt=0.
  - Lockout entered while in ARMED or ENTRY -> ALARM (tamper).
  - Lockout in DISARMED, EXIT or ALARM does not change state.
- Timers are down-counters of width clog2(max+1). There is no wrap: each counter stops at 0.
- Changing zone_mask mid-ARMED takes effect the same cycle.

Optional Feature:
- Macro: SIREN_TIMEOUT_EN.
- Defined:
  - ALARM auto-returns to ARMED after SIREN_CYCLES cycles with siren=0.
  - Zones set in zone_mem are auto-bypassed until the next disarm, so a stuck-open zone cannot retrigger.
  - good still disarms at any time.
  - Other zones can retrigger normally.
- Undefined: ALARM persists until good. There is no timer and no auto-bypass logic.

Test Plan:
- Arm and timeout: all zones closed, code 4'hA -> beeper=1, state=1 for 8 cycles, then state=2, armed=1, siren=0.
- Delayed zone: ARMED, zone=6'b000001 -> state=3 next cycle; no code for 16 cycles -> state=4, siren=1, zone_mem=6'b000001. Then code 4'hA -> state=0, zone_mem still 6'b000001.
- Instant zone and priority:
  - In ENTRY, zone=6'b000100 -> state=4 next cycle.
  - Separately, code 4'hA in the same cycle as zone=6'b000010 while ARMED -> state=0, siren never asserted.
- Bypass and not-ready:
  - zone=6'b100000 with zone_mask=0, code 4'hA -> stays state=0, ready=0.
  - With zone_mask=6'b100000 -> arms.
  - While ARMED, zone 5 toggling -> no transition.
- Lockout: three codes 4'h3 while ARMED -> lockout=1, state=4. Code 4'hA during the 32-cycle lockout -> ignored, siren=1. After lockout, code 4'hA -> state=0, fail_cnt=0.
- Async reset mid-ENTRY (rst pulsed between clock edges) -> immediately state=0, siren=0, zone_mem=0, lockout=0.
- With SIREN_TIMEOUT_EN, zone 1 held open: after 64 cycles of ALARM -> state=2, siren=0, no retrigger from zone 1.

Source files
------------

// File: rtl/sist_seguridad_zonas.sv
// N-zone alarm controller: exit/entry delays, instant vs delayed zones, tripped-zone memory, wrong-code lockout.
// Optional `SIREN_TIMEOUT_EN: ALARM auto-returns to ARMED after SIREN_CYCLES and tripped zones are auto-bypassed.
module sist_seguridad_zonas #(
    parameter int                  N_ZONES      = 6,
    parameter int                  CODE_W       = 4,
    parameter logic [CODE_W-1:0]   PASSCODE     = 4'hA,
    parameter logic [N_ZONES-1:0]  DELAY_ZONES  = 6'b000001,
    parameter int                  EXIT_CYCLES  = 8,
    parameter int                  ENTRY_CYCLES = 16,
    parameter int                  MAX_TRIES    = 3,
    parameter int                  LOCK_CYCLES  = 32,
    parameter int                  SIREN_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               code_vld,
    input  logic [CODE_W-1:0]                  code,
    input  logic [N_ZONES-1:0]                 zone,
    input  logic [N_ZONES-1:0]                 zone_mask,
    output logic                               armed,
    output logic                               siren,
    output logic                               beeper,
    output logic                               lockout,
    output logic                               ready,
    output logic [N_ZONES-1:0]                 zone_mem,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt,
    output logic [2:0]                         state
);
    localparam int FW   = $clog2(MAX_TRIES + 1);
    localparam int LW   = $clog2(LOCK_CYCLES + 1);
    localparam int T_EE = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
`ifdef SIREN_TIMEOUT_EN
    localparam int T_MAX = (T_EE > SIREN_CYCLES) ? T_EE : SIREN_CYCLES;
`else
    localparam int T_MAX = T_EE;
`endif
    localparam int TW = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } st_t;

    st_t               st_reg, st_next;
    logic [TW-1:0]     tmr_reg, tmr_next;
    logic [LW-1:0]     lock_tmr_reg;
    logic [N_ZONES-1:0] mem_next, bypass, active;
    logic              good, bad, lock_start, inst_hit;

    // One shared timer serves EXIT, ENTRY and ALARM since they are mutually exclusive.
`ifdef SIREN_TIMEOUT_EN
    assign bypass = (st_reg != S_DISARMED) ? zone_mem : '0;
`else
    assign bypass = '0;
`endif
    assign active     = zone & ~zone_mask & ~bypass;
    assign ready      = ~|active;
    assign good       = code_vld & ~lockout & (code == PASSCODE);
    assign bad        = code_vld & ~lockout & (code != PASSCODE);
    assign lock_start = bad & (fail_cnt == FW'(MAX_TRIES - 1));
    assign inst_hit   = |(active & ~DELAY_ZONES);
    assign state      = st_reg;

    always_comb begin
        st_next  = st_reg;
        tmr_next = tmr_reg;
        mem_next = zone_mem;
        case (st_reg)
            S_DISARMED: begin
                if (good && ready) begin
                    st_next  = S_EXIT;
                    tmr_next = TW'(EXIT_CYCLES - 1);
                    mem_next = '0;
                end
            end
            S_EXIT: begin
                if (good)                 st_next = S_DISARMED;
                else if (tmr_reg == '0)   st_next = S_ARMED;
                else                      tmr_next = tmr_reg - TW'(1);
            end
            S_ARMED: begin
                if (good) st_next = S_DISARMED;
                else begin
                    mem_next = zone_mem | active;
                    if (lock_start || inst_hit) st_next = S_ALARM;
                    else if (|active) begin
                        st_next  = S_ENTRY;
                        tmr_next = TW'(ENTRY_CYCLES - 1);
                    end
                end
            end
            S_ENTRY: begin
                if (good) st_next = S_DISARMED;
                else begin
                    mem_next = zone_mem | active;
                    if (lock_start || inst_hit || tmr_reg == '0) st_next = S_ALARM;
                    else                                          tmr_next = tmr_reg - TW'(1);
                end
            end
            S_ALARM: begin
                if (good) st_next = S_DISARMED;
                else begin
                    mem_next = zone_mem | active;
`ifdef SIREN_TIMEOUT_EN
                    if (tmr_reg == '0) st_next = S_ARMED;
                    else               tmr_next = tmr_reg - TW'(1);
`endif
                end
            end
            default: st_next = S_DISARMED;
        endcase
`ifdef SIREN_TIMEOUT_EN
        if (st_next == S_ALARM && st_reg != S_ALARM) tmr_next = TW'(SIREN_CYCLES - 1);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_reg       <= S_DISARMED;
            tmr_reg      <= '0;
            lock_tmr_reg <= '0;
            zone_mem     <= '0;
            fail_cnt     <= '0;
            lockout      <= 1'b0;
            armed        <= 1'b0;
            siren        <= 1'b0;
            beeper       <= 1'b0;
        end else begin
            st_reg   <= st_next;
            tmr_reg  <= tmr_next;
            zone_mem <= mem_next;
            armed    <= (st_next != S_DISARMED);
            siren    <= (st_next == S_ALARM);
            beeper   <= (st_next == S_EXIT) || (st_next == S_ENTRY);
            if (lockout) begin
                if (lock_tmr_reg == '0) begin
                    lockout  <= 1'b0;
                    fail_cnt <= '0;
                end else begin
                    lock_tmr_reg <= lock_tmr_reg - LW'(1);
                end
            end else if (good) begin
                fail_cnt <= '0;
            end else if (bad) begin
                fail_cnt <= fail_cnt + FW'(1);
                if (lock_start) begin
                    lockout      <= 1'b1;
                    lock_tmr_reg <= LW'(LOCK_CYCLES - 1);
                end
            end
        end
    end
endmodule
